openav1_quantize_4x4: RTL
=========================

// Module: openav1_quantize_4x4
// PURPOSE
//  Downstream of the 4x4 forward DCT: takes one packed 4x4 coefficient block, scales each
//  coefficient by a block-wide quantiser multiplier, rounds, shifts and saturates it, and
//  reports the end-of-block (EOB) position for the entropy coder. It is a serial engine:
//  one shared multiplier handles one coefficient per cycle. Valid/ready handshake on both sides.
// PARAMETERS
//  N        4   matrix dimension (block is N x N)
//  COEF_W   8   coefficient width, unsigned, in and out
//  QMULT_W  16  quantiser multiplier width, unsigned
//  QSHIFT   8   right shift after multiply (qmult 256 = gain 1.0); must be >= 1
// PORTS
//  clk        in   1                 clock, rising edge
//  reset      in   1                 asynchronous, active-low reset
//  in_valid   in   1                 in_block/in_qmult valid
//  in_ready   out  1                 block accepts a new block
//  in_block   in   N*N*COEF_W (128)  row-major; [0][0] in bits 127:120, [3][3] in bits 7:0
//  in_qmult   in   QMULT_W           multiplier, sampled together with in_block
//  out_valid  out  1                 out_block/out_eob valid
//  out_ready  in   1                 consumer accepts the output
//  out_block  out  128               quantised block, same packing as in_block
//  out_eob    out  5                 (last nonzero row-major index)+1; 0 if all zero
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, idx=0, out_valid=0, out_block=0, out_eob=0; in_ready=1.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1. On in_valid&&in_ready: latch in_block and in_qmult, clear the result
//         register and the EOB register, set idx=0, go to RUN.
//   RUN:  in_ready=0. Each cycle: element idx (row-major, 0..15) -> quantised value written to
//         result[idx]; if the value != 0 then eob<=idx+1. idx++. At idx==15, go to DONE.
//   DONE: out_valid=1, in_ready=0. out_block/out_eob are stable while out_valid=1.
//         On out_ready: out_valid falls, go to IDLE.
//  Latency: out_valid rises after the 16th rising edge following the accepting edge.
//   Throughput: at best one block per 18 cycles (accept, 16 RUN, 1 DONE handshake).
//  Arithmetic per element: p = c*qmult (COEF_W+QMULT_W = 24 bits, unsigned);
//   r = (p + 2^(QSHIFT-1)) >> QSHIFT, computed 25 bits wide with no overflow;
//   q = (r > 2^COEF_W-1) ? 2^COEF_W-1 : r[COEF_W-1:0].
//  Boundary cases:
//   - qmult=0: every q=0 and out_eob=0.
//   - Saturation: 255*65535 gives q=255.
//   - EOB is updated only by nonzero outputs, so the highest nonzero index wins.
//   - in_valid during RUN/DONE is ignored; the inputs are not sampled.
//   - out_ready high in IDLE/RUN has no effect.
//   - out_ready held low in DONE: stay in DONE indefinitely with the outputs held.
//   - No overlap: a new block is accepted only in IDLE, never on the same edge as the
//     DONE handshake.
//   - reset asserted mid-RUN/DONE: the block is abandoned immediately; all reset values apply.
//   - in_block/in_qmult may change after acceptance without affecting the result.
// STRUCTURE
//  Shared package openav1_pkg holds: N, COEF_W, BLOCK_W (N*N*COEF_W), the quant_state_t enum
//   {IDLE,RUN,DONE}, and the function that converts a row-major index to a bit offset.
//  Sub-module openav1_quant_scalar (combinational): inputs c and qmult -> output q
//   (multiply, round, shift, saturate). It is instantiated once and driven by the idx mux.
//  The top level holds the FSM, idx counter, latched operands, result register and EOB register.
// TESTING
//  1 Reset: hold reset=0 -> out_valid=0, in_ready=1, out_block=0, out_eob=0; assert async
//    mid-clock.
//  2 All coefs 100, qmult=256 -> every q=100, out_eob=16; out_valid exactly 16 edges after
//    accept.
//  3 Rounding, qmult=128: coefs 3,1,0 -> 2,1,0 ((384+128)>>8=2, (128+128)>>8=1);
//    qmult=0 -> all 0, eob=0.
//  4 Saturation: all coefs 255, qmult=65535 -> all q=255, out_eob=16.
//  5 EOB: only [1][2]=50 (idx 6), qmult=256 -> out_eob=7; only [3][3]=1, qmult=64 -> q=0,
//    out_eob=0.
//  6 Handshake: out_ready low 5 cycles in DONE -> outputs held, in_ready=0, in_valid ignored;
//    then a second block completes correctly; reset=0 mid-RUN -> IDLE, out_valid never rises.

Source files
------------

// File: rtl/openav1_pkg.sv
// Shared constants, FSM state type and index helper for the 4x4 quantiser.
package openav1_pkg;

    localparam int N       = 4;
    localparam int COEF_W  = 8;
    localparam int QMULT_W = 16;
    localparam int QSHIFT  = 8;
    localparam int BLOCK_W = N * N * COEF_W;
    localparam int IDX_W   = 4;
    localparam int EOB_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } quant_state_t;

    // Row-major element 0 lives in the most significant byte of the packed block.
    function automatic int coef_offset(input logic [IDX_W-1:0] idx);
        return BLOCK_W - COEF_W * (int'(idx) + 1);
    endfunction

endpackage

// File: rtl/openav1_quantize_4x4_if.sv
// Valid/ready block interface between the DCT stage, the quantiser and the entropy coder.
interface openav1_quantize_4x4_if;
    import openav1_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [BLOCK_W-1:0]    in_block;
    logic [QMULT_W-1:0]    in_qmult;
    logic                  out_valid;
    logic                  out_ready;
    logic [BLOCK_W-1:0]    out_block;
    logic [EOB_W-1:0]      out_eob;

    modport master (
        output in_valid, in_block, in_qmult, out_ready,
        input  in_ready, out_valid, out_block, out_eob
    );

    modport slave (
        input  in_valid, in_block, in_qmult, out_ready,
        output in_ready, out_valid, out_block, out_eob
    );

endinterface

// File: rtl/openav1_quant_scalar.sv
// Combinational multiply, round-half-up, shift and saturate for one coefficient.
module openav1_quant_scalar
    import openav1_pkg::*;
(
    input  logic [COEF_W-1:0]  c,
    input  logic [QMULT_W-1:0] qmult,
    output logic [COEF_W-1:0]  q
);

    localparam int PROD_W = COEF_W + QMULT_W;
    localparam logic [PROD_W:0] ROUND   = (PROD_W + 1)'(1) << (QSHIFT - 1);
    localparam logic [PROD_W:0] SAT_MAX = (PROD_W + 1)'((1 << COEF_W) - 1);

    logic [PROD_W-1:0] prod;
    logic [PROD_W:0]   rounded;
    logic [PROD_W:0]   shifted;

    // The extra top bit keeps the rounding add from overflowing at full scale.
    always_comb begin
        prod    = {{QMULT_W{1'b0}}, c} * {{COEF_W{1'b0}}, qmult};
        rounded = {1'b0, prod} + ROUND;
        shifted = rounded >> QSHIFT;
        q       = (shifted > SAT_MAX) ? {COEF_W{1'b1}} : shifted[COEF_W-1:0];
    end

endmodule

// File: rtl/openav1_quantize_4x4.sv
// Serial 4x4 quantiser: one coefficient per cycle through a shared scalar unit, plus EOB tracking.
module openav1_quantize_4x4
    import openav1_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    openav1_quantize_4x4_if.slave  bus
);

    quant_state_t        state;
    quant_state_t        next_state;
    logic [IDX_W-1:0]    idx;
    logic [BLOCK_W-1:0]  block_q;
    logic [QMULT_W-1:0]  qmult_q;
    logic [BLOCK_W-1:0]  result;
    logic [EOB_W-1:0]    eob;
    logic [COEF_W-1:0]   cur_coef;
    logic [COEF_W-1:0]   cur_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.in_valid) next_state = RUN;
            RUN:     if (idx == IDX_W'(N * N - 1)) next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.out_block = result;
        bus.out_eob   = eob;
    end

    assign cur_coef = block_q[coef_offset(idx) +: COEF_W];

    openav1_quant_scalar u_scalar (
        .c     (cur_coef),
        .qmult (qmult_q),
        .q     (cur_q)
    );

    // Operands are captured once at acceptance so later input changes cannot leak in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx     <= '0;
            block_q <= '0;
            qmult_q <= '0;
            result  <= '0;
            eob     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        block_q <= bus.in_block;
                        qmult_q <= bus.in_qmult;
                        result  <= '0;
                        eob     <= '0;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    result[coef_offset(idx) +: COEF_W] <= cur_q;
                    if (cur_q != '0) begin
                        eob <= EOB_W'(idx) + EOB_W'(1);
                    end
                    idx <= idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
